// File: rtl/retire_buffer_pkg.sv
// Shared types for the retire buffer.
//   retireState_e : occupancy of the two-entry skid buffer
//   retireEntry_t : one buffered execute result (result, destination, write enable)
// Build option: defining RETIRE_CNT_EN enables the retired-instruction counter in
// retire_buffer. The types in this package are the same in both builds.
package retire_buffer_pkg;

  localparam int unsigned XlenDef    = 32;
  localparam int unsigned RfAddrWDef = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } retireState_e;

  typedef struct packed {
    logic [XlenDef-1:0]    result;
    logic [RfAddrWDef-1:0] rd;
    logic                  we;
  } retireEntry_t;

endpackage

// File: rtl/retire_buffer.sv
// Two-entry skid buffer between the execute units and the register-file write port.
// A result accepted on the input handshake (valid_i && ready_o) appears on valid_o
// the next cycle; a second result can be parked in the skid entry while writeback
// stalls, so ready_o is registered and has no combinational path from ready_i.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   flush_i             drop both entries and the current input
//   valid_i / ready_o   input handshake; result_i, rd_i, we_i carry the entry
//   valid_o / ready_i   output handshake; result_o, rd_o, we_o expose the head
//   fwd_valid_o         head is valid and writes a register (bypass source)
//   instret_o           retired-instruction count
//
// Build option: RETIRE_CNT_EN defined -> instret_o counts output handshakes
// (wrapping modulo 2^INSTRET_W); undefined -> no counter, instret_o tied to 0.
// The port list is identical in both builds.
module retire_buffer
  import retire_buffer_pkg::*;
#(
  // Entry layout in the package fixes the result and register-index widths.
  parameter int unsigned XLEN      = XlenDef,
  parameter int unsigned RF_ADDR_W = RfAddrWDef,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [XLEN-1:0]      result_i,
  input  logic [RF_ADDR_W-1:0] rd_i,
  input  logic                 we_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      result_o,
  output logic [RF_ADDR_W-1:0] rd_o,
  output logic                 we_o,
  output logic                 fwd_valid_o,
  output logic [INSTRET_W-1:0] instret_o
);

  retireState_e state_q, state_d;
  retireEntry_t head_q, head_d;
  retireEntry_t skid_q, skid_d;
  retireEntry_t in_entry;
  logic         ready_q;
  logic         in_hs;
  logic         out_hs;

  assign in_entry = '{result: result_i, rd: rd_i, we: we_i};
  assign in_hs    = valid_i && ready_q;
  assign out_hs   = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // Flush wins over loads; an output handshake this cycle still completes.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            state_d = ONE;
            head_d  = in_entry;
          end
        end
        ONE: begin
          if (in_hs && out_hs) begin
            head_d = in_entry;
          end else if (in_hs) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (out_hs) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_hs) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      // Registered copy of (state != FULL) for the next cycle.
      ready_q <= (state_d != FULL);
    end
  end

  assign ready_o     = ready_q;
  assign valid_o     = (state_q != EMPTY);
  assign result_o    = head_q.result;
  assign rd_o        = head_q.rd;
  // x0 entries still retire but never write the register file.
  assign we_o        = head_q.we && (head_q.rd != '0);
  assign fwd_valid_o = valid_o && we_o;

`ifdef RETIRE_CNT_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (out_hs) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
